// File: rtl/mdu_issue_queue_pkg.sv
// Shared types for the MDU issue queue and its slots.
package mdu_issue_queue_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  rob_id_t;

  typedef struct packed {
    logic [3:0] op;
    rob_id_t    rob_id;
  } decode_info_t;

  typedef struct packed {
    word_t   data;
    rob_id_t tag;
    logic    valid;
  } iq_operand_t;

endpackage

// File: rtl/mdu_iq_entry.sv
// One issue-queue slot: occupancy, decoded instruction, operands with CDB wakeup.
// Optional macro IQ_ENQ_WAKEUP_EN: operands being written also snoop the same-cycle CDB.
module mdu_iq_entry
  import mdu_issue_queue_pkg::*;
#(
  parameter int REG_COUNT = 2,
  parameter int CDB_COUNT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         load,
  input  logic                         free,
  input  decode_info_t                 load_di,
  input  iq_operand_t [REG_COUNT-1:0]  load_ops,
  input  word_t       [CDB_COUNT-1:0]  cdb_data_i,
  input  rob_id_t     [CDB_COUNT-1:0]  cdb_reg_id_i,
  input  logic        [CDB_COUNT-1:0]  cdb_valid_i,
  output decode_info_t                 di,
  output word_t       [REG_COUNT-1:0]  data,
  output logic                         ready
);

  logic                        occupied_r;
  decode_info_t                di_r;
  iq_operand_t [REG_COUNT-1:0] ops_r;
  iq_operand_t [REG_COUNT-1:0] load_ops_s;
  iq_operand_t [REG_COUNT-1:0] held_ops_s;
  logic                        ready_s;

  // Channels are scanned high to low so the lowest matching index is written last.
  function automatic iq_operand_t wake(input iq_operand_t op,
                                       input word_t   [CDB_COUNT-1:0] bus_data,
                                       input rob_id_t [CDB_COUNT-1:0] bus_tag,
                                       input logic    [CDB_COUNT-1:0] bus_valid);
    iq_operand_t res;
    res = op;
    for (int c = CDB_COUNT - 1; c >= 0; c--) begin
      if (!op.valid && bus_valid[c] && (bus_tag[c] == op.tag)) begin
        res.data  = bus_data[c];
        res.valid = 1'b1;
      end
    end
    return res;
  endfunction

  // Next operand values for the load and hold paths.
  always_comb begin
    load_ops_s = '0;
    held_ops_s = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
`ifdef IQ_ENQ_WAKEUP_EN
      load_ops_s[r] = wake(load_ops[r], cdb_data_i, cdb_reg_id_i, cdb_valid_i);
`else
      load_ops_s[r] = load_ops[r];
`endif
      held_ops_s[r] = wake(ops_r[r], cdb_data_i, cdb_reg_id_i, cdb_valid_i);
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied_r <= 1'b0;
      di_r       <= '0;
      ops_r      <= '0;
    end else if (flush) begin
      occupied_r <= 1'b0;
    end else if (load) begin
      occupied_r <= 1'b1;
      di_r       <= load_di;
      ops_r      <= load_ops_s;
    end else begin
      occupied_r <= occupied_r && !free;
      ops_r      <= held_ops_s;
    end
  end

  // Ready once occupied and every operand is present; expose operand data.
  always_comb begin
    ready_s = occupied_r;
    data    = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      ready_s = ready_s & ops_r[r].valid;
      data[r] = ops_r[r].data;
    end
  end

  assign ready = ready_s;
  assign di    = di_r;

endmodule

// File: rtl/mdu_issue_queue_sva.sv
// Protocol checker: dispatch must not present lanes while enq_ready_o is low.
module mdu_issue_queue_sva #(
  parameter int DISP_WIDTH = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic [DISP_WIDTH-1:0] enq_valid_i,
  input logic                  enq_ready_o
);

  enq_when_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !((|enq_valid_i) && !enq_ready_o));

endmodule

// File: rtl/mdu_issue_queue.sv
// In-order MDU issue queue: circular buffer of mdu_iq_entry slots, head-only select, registered issue port.
// Optional macro IQ_ENQ_WAKEUP_EN enables same-cycle CDB capture on enqueue (see mdu_iq_entry).
module mdu_issue_queue
  import mdu_issue_queue_pkg::*;
#(
  parameter int IQ_SIZE    = 8,
  parameter int DISP_WIDTH = 2,
  parameter int REG_COUNT  = 2,
  parameter int CDB_COUNT  = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         flush,
  input  logic         [DISP_WIDTH-1:0]                enq_valid_i,
  input  decode_info_t [DISP_WIDTH-1:0]                enq_di_i,
  input  word_t        [DISP_WIDTH-1:0][REG_COUNT-1:0] enq_data_i,
  input  rob_id_t      [DISP_WIDTH-1:0][REG_COUNT-1:0] enq_reg_id_i,
  input  logic         [DISP_WIDTH-1:0][REG_COUNT-1:0] enq_data_valid_i,
  output logic                                         enq_ready_o,
  input  word_t        [CDB_COUNT-1:0]                 cdb_data_i,
  input  rob_id_t      [CDB_COUNT-1:0]                 cdb_reg_id_i,
  input  logic         [CDB_COUNT-1:0]                 cdb_valid_i,
  output logic                                         issue_valid_o,
  input  logic                                         issue_ready_i,
  output decode_info_t                                 issue_di_o,
  output word_t        [REG_COUNT-1:0]                 issue_data_o,
  output logic         [$clog2(IQ_SIZE+1)-1:0]         count_o
);

  localparam int PTR_W = $clog2(IQ_SIZE);
  localparam int CNT_W = $clog2(IQ_SIZE + 1);

  logic [PTR_W-1:0]            head_r;
  logic [PTR_W-1:0]            tail_r;
  logic [CNT_W-1:0]            count_r;
  logic                        enq_ready_r;
  logic                        issue_valid_r;
  decode_info_t                issue_di_r;
  word_t [REG_COUNT-1:0]       issue_data_r;

  logic [IQ_SIZE-1:0]          load_s;
  logic [IQ_SIZE-1:0]          free_s;
  logic [IQ_SIZE-1:0]          ready_s;
  decode_info_t                load_di_s  [IQ_SIZE];
  iq_operand_t [REG_COUNT-1:0] load_ops_s [IQ_SIZE];
  decode_info_t                di_s       [IQ_SIZE];
  word_t [REG_COUNT-1:0]       data_s     [IQ_SIZE];
  logic [CNT_W-1:0]            enq_cnt_s;
  logic [CNT_W-1:0]            count_nxt_s;
  logic                        issue_load_s;

  for (genvar g = 0; g < IQ_SIZE; g++) begin : g_entry
    mdu_iq_entry #(.REG_COUNT(REG_COUNT), .CDB_COUNT(CDB_COUNT)) u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .load         (load_s[g]),
      .free         (free_s[g]),
      .load_di      (load_di_s[g]),
      .load_ops     (load_ops_s[g]),
      .cdb_data_i   (cdb_data_i),
      .cdb_reg_id_i (cdb_reg_id_i),
      .cdb_valid_i  (cdb_valid_i),
      .di           (di_s[g]),
      .data         (data_s[g]),
      .ready        (ready_s[g])
    );
  end

  // Pack valid lanes in ascending order into tail, tail+1, ...
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot      = '0;
    load_s    = '0;
    enq_cnt_s = '0;
    for (int e = 0; e < IQ_SIZE; e++) begin
      load_di_s[e]  = '0;
      load_ops_s[e] = '0;
    end
    for (int l = 0; l < DISP_WIDTH; l++) begin
      slot = tail_r + PTR_W'(enq_cnt_s);
      if (enq_valid_i[l] && enq_ready_r) begin
        load_s[slot]    = 1'b1;
        load_di_s[slot] = enq_di_i[l];
        for (int r = 0; r < REG_COUNT; r++) begin
          load_ops_s[slot][r].data  = enq_data_i[l][r];
          load_ops_s[slot][r].tag   = enq_reg_id_i[l][r];
          load_ops_s[slot][r].valid = enq_data_valid_i[l][r];
        end
        enq_cnt_s = enq_cnt_s + CNT_W'(1);
      end else begin
        enq_cnt_s = enq_cnt_s;
      end
    end
  end

  assign issue_load_s = (!issue_valid_r || issue_ready_i) && ready_s[head_r];

  // Free the head on issue; occupancy after this cycle's enqueue and issue.
  always_comb begin
    free_s         = '0;
    free_s[head_r] = issue_load_s;
    count_nxt_s    = count_r + enq_cnt_s - CNT_W'(issue_load_s);
  end

  // Pointers, occupancy counter and registered enqueue credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      enq_ready_r <= 1'b1;
    end else if (flush) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      enq_ready_r <= 1'b1;
    end else begin
      head_r      <= head_r + PTR_W'(issue_load_s);
      tail_r      <= tail_r + PTR_W'(enq_cnt_s);
      count_r     <= count_nxt_s;
      enq_ready_r <= (CNT_W'(IQ_SIZE) - count_nxt_s) >= CNT_W'(DISP_WIDTH);
    end
  end

  // Issue output register; holds while the MDU back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_r <= 1'b0;
      issue_di_r    <= '0;
      issue_data_r  <= '0;
    end else if (flush) begin
      issue_valid_r <= 1'b0;
      issue_di_r    <= '0;
      issue_data_r  <= '0;
    end else if (issue_load_s) begin
      issue_valid_r <= 1'b1;
      issue_di_r    <= di_s[head_r];
      issue_data_r  <= data_s[head_r];
    end else if (issue_ready_i) begin
      issue_valid_r <= 1'b0;
    end
  end

  assign enq_ready_o   = enq_ready_r;
  assign issue_valid_o = issue_valid_r;
  assign issue_di_o    = issue_di_r;
  assign issue_data_o  = issue_data_r;
  assign count_o       = count_r;

  mdu_issue_queue_sva #(.DISP_WIDTH(DISP_WIDTH)) u_sva (
    .clk         (clk),
    .rst_n       (rst_n),
    .enq_valid_i (enq_valid_i),
    .enq_ready_o (enq_ready_r)
  );

endmodule

// File: tb/tb_mdu_issue_queue.sv
// Directed self-checking bench for mdu_issue_queue (default parameters).
module tb_mdu_issue_queue;
  import mdu_issue_queue_pkg::*;

  logic                         clk;
  logic                         rst_n;
  logic                         flush;
  logic         [1:0]           enq_valid_i;
  decode_info_t [1:0]           enq_di_i;
  word_t        [1:0][1:0]      enq_data_i;
  rob_id_t      [1:0][1:0]      enq_reg_id_i;
  logic         [1:0][1:0]      enq_data_valid_i;
  logic                         enq_ready_o;
  word_t        [1:0]           cdb_data_i;
  rob_id_t      [1:0]           cdb_reg_id_i;
  logic         [1:0]           cdb_valid_i;
  logic                         issue_valid_o;
  logic                         issue_ready_i;
  decode_info_t                 issue_di_o;
  word_t        [1:0]           issue_data_o;
  logic         [3:0]           count_o;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_issue_queue dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .enq_valid_i      (enq_valid_i),
    .enq_di_i         (enq_di_i),
    .enq_data_i       (enq_data_i),
    .enq_reg_id_i     (enq_reg_id_i),
    .enq_data_valid_i (enq_data_valid_i),
    .enq_ready_o      (enq_ready_o),
    .cdb_data_i       (cdb_data_i),
    .cdb_reg_id_i     (cdb_reg_id_i),
    .cdb_valid_i      (cdb_valid_i),
    .issue_valid_o    (issue_valid_o),
    .issue_ready_i    (issue_ready_i),
    .issue_di_o       (issue_di_o),
    .issue_data_o     (issue_data_o),
    .count_o          (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [3:0] op, input word_t d0, input word_t d1,
                          input rob_id_t t0, input logic v0);
    enq_valid_i[l]         = 1'b1;
    enq_di_i[l].op         = op;
    enq_di_i[l].rob_id     = 6'd0;
    enq_data_i[l][0]       = d0;
    enq_data_i[l][1]       = d1;
    enq_reg_id_i[l][0]     = t0;
    enq_reg_id_i[l][1]     = 6'd0;
    enq_data_valid_i[l][0] = v0;
    enq_data_valid_i[l][1] = 1'b1;
  endtask

  task automatic set_seq(input int l, input int k);
    set_lane(l, 4'(k), 32'(k) * 32'h100, 32'h1000 + 32'(k), 6'd0, 1'b1);
  endtask

  task automatic idle_inputs();
    enq_valid_i = 2'b00;
    cdb_valid_i = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_ready_i = 1'b0;
    enq_valid_i = '0; enq_di_i = '0; enq_data_i = '0; enq_reg_id_i = '0; enq_data_valid_i = '0;
    cdb_data_i = '0; cdb_reg_id_i = '0; cdb_valid_i = '0;
    tick(); tick();
    check_eq("rst_valid", 64'(issue_valid_o), 64'd0);
    check_eq("rst_ready", 64'(enq_ready_o), 64'd1);
    check_eq("rst_count", 64'(count_o), 64'd0);
    check_eq("rst_data", 64'(issue_data_o), 64'd0);
    check_eq("rst_di", 64'(issue_di_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Two lanes, all operands present: issue in lane order.
    issue_ready_i = 1'b1;
    set_lane(0, 4'd1, 32'h11, 32'h12, 6'd0, 1'b1);
    set_lane(1, 4'd2, 32'h21, 32'h22, 6'd0, 1'b1);
    tick(); idle_inputs();
    check_eq("t1_count2", 64'(count_o), 64'd2);
    check_eq("t1_novalid", 64'(issue_valid_o), 64'd0);
    tick();
    check_eq("t1_valid_a", 64'(issue_valid_o), 64'd1);
    check_eq("t1_op_a", 64'(issue_di_o.op), 64'd1);
    check_eq("t1_d0_a", 64'(issue_data_o[0]), 64'h11);
    check_eq("t1_d1_a", 64'(issue_data_o[1]), 64'h12);
    check_eq("t1_count1", 64'(count_o), 64'd1);
    tick();
    check_eq("t1_op_b", 64'(issue_di_o.op), 64'd2);
    check_eq("t1_d0_b", 64'(issue_data_o[0]), 64'h21);
    check_eq("t1_count0", 64'(count_o), 64'd0);
    tick();
    check_eq("t1_idle", 64'(issue_valid_o), 64'd0);

    // Operand 0 waits for tag 5 on CDB1.
    set_lane(0, 4'd3, 32'h0, 32'h33, 6'd5, 1'b0);
    tick(); idle_inputs();
    tick();
    check_eq("t2_wait", 64'(issue_valid_o), 64'd0);
    cdb_reg_id_i[0] = 6'd5; cdb_data_i[0] = 32'hBAD0;
    cdb_reg_id_i[1] = 6'd5; cdb_data_i[1] = 32'hDEAD; cdb_valid_i = 2'b10;
    tick(); idle_inputs();
    check_eq("t2_not_early", 64'(issue_valid_o), 64'd0);
    tick();
    check_eq("t2_valid", 64'(issue_valid_o), 64'd1);
    check_eq("t2_d0", 64'(issue_data_o[0]), 64'hDEAD);
    check_eq("t2_d1", 64'(issue_data_o[1]), 64'h33);
    tick();
    check_eq("t2_idle", 64'(issue_valid_o), 64'd0);

    // Both channels match: lowest index wins.
    set_lane(0, 4'd4, 32'h0, 32'h44, 6'd5, 1'b0);
    tick(); idle_inputs();
    cdb_data_i[0] = 32'h1; cdb_data_i[1] = 32'h2; cdb_valid_i = 2'b11;
    tick(); idle_inputs();
    tick();
    check_eq("t3_valid", 64'(issue_valid_o), 64'd1);
    check_eq("t3_prio", 64'(issue_data_o[0]), 64'h1);
    tick();

    // Fill under back-pressure; tail wraps from slot 4 around past 7.
    issue_ready_i = 1'b0;
    set_seq(0, 1); set_seq(1, 2); tick();
    check_eq("t4_c2", 64'(count_o), 64'd2);
    set_seq(0, 3); set_seq(1, 4); tick();
    check_eq("t4_c3", 64'(count_o), 64'd3);
    check_eq("t4_out1", 64'(issue_di_o.op), 64'd1);
    set_seq(0, 5); set_seq(1, 6); tick();
    check_eq("t4_c5", 64'(count_o), 64'd5);
    idle_inputs(); set_seq(0, 7); tick();
    check_eq("t4_c6", 64'(count_o), 64'd6);
    check_eq("t4_rdy6", 64'(enq_ready_o), 64'd1);
    set_seq(0, 8); set_seq(1, 9); tick(); idle_inputs();
    check_eq("t4_c8", 64'(count_o), 64'd8);
    check_eq("t4_full", 64'(enq_ready_o), 64'd0);
    tick();
    check_eq("t4_hold_v", 64'(issue_valid_o), 64'd1);
    check_eq("t4_hold_op", 64'(issue_di_o.op), 64'd1);
    check_eq("t4_hold_d", 64'(issue_data_o[0]), 64'h100);
    issue_ready_i = 1'b1;
    tick();
    check_eq("t4_op2", 64'(issue_di_o.op), 64'd2);
    check_eq("t4_c7", 64'(count_o), 64'd7);
    check_eq("t4_rdy7", 64'(enq_ready_o), 64'd0);
    tick();
    check_eq("t4_op3", 64'(issue_di_o.op), 64'd3);
    check_eq("t4_rdy_back", 64'(enq_ready_o), 64'd1);
    for (int k = 4; k <= 9; k++) begin
      tick();
      check_eq("t4_seq_op", 64'(issue_di_o.op), 64'(k));
      check_eq("t4_seq_d0", 64'(issue_data_o[0]), 64'(k) * 64'h100);
      check_eq("t4_seq_d1", 64'(issue_data_o[1]), 64'h1000 + 64'(k));
    end
    check_eq("t4_empty", 64'(count_o), 64'd0);
    tick();
    check_eq("t4_idle", 64'(issue_valid_o), 64'd0);

    // Flush with five queued entries and a held output.
    issue_ready_i = 1'b0;
    set_seq(0, 1); set_seq(1, 2); tick();
    set_seq(0, 3); set_seq(1, 4); tick();
    set_seq(0, 5); set_seq(1, 6); tick(); idle_inputs();
    check_eq("t5_c5", 64'(count_o), 64'd5);
    check_eq("t5_v", 64'(issue_valid_o), 64'd1);
    flush = 1'b1;
    tick(); flush = 1'b0;
    check_eq("t5_fv", 64'(issue_valid_o), 64'd0);
    check_eq("t5_fc", 64'(count_o), 64'd0);
    check_eq("t5_fr", 64'(enq_ready_o), 64'd1);
    issue_ready_i = 1'b1;
    set_lane(0, 4'hA, 32'hA0, 32'hA1, 6'd0, 1'b1);
    tick(); idle_inputs();
    tick();
    check_eq("t5_after_op", 64'(issue_di_o.op), 64'hA);
    check_eq("t5_after_d", 64'(issue_data_o[0]), 64'hA0);
    tick();

    // Same-cycle CDB broadcast during enqueue.
    set_lane(0, 4'hB, 32'h0, 32'h66, 6'd9, 1'b0);
    cdb_reg_id_i[0] = 6'd9; cdb_data_i[0] = 32'h77; cdb_valid_i = 2'b01;
    tick(); idle_inputs();
    tick();
`ifdef IQ_ENQ_WAKEUP_EN
    check_eq("t6_valid", 64'(issue_valid_o), 64'd1);
    check_eq("t6_data", 64'(issue_data_o[0]), 64'h77);
`else
    check_eq("t6_stuck", 64'(issue_valid_o), 64'd0);
    check_eq("t6_count", 64'(count_o), 64'd1);
`endif
    flush = 1'b1;
    tick(); flush = 1'b0;
    check_eq("t6_flushed", 64'(count_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
